// File: rtl/pwm_pkg.sv
// Register map, bit positions and address decode helper for the PWM register file.
package pwm_pkg;

    localparam logic [7:0] ADDR_PERIOD     = 8'h00;
    localparam logic [7:0] ADDR_CTRL       = 8'h04;
    localparam logic [7:0] ADDR_PRESCALER  = 8'h08;
    localparam logic [7:0] ADDR_DEADTIME   = 8'h0C;
    localparam logic [7:0] ADDR_STATUS     = 8'h10;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h14;
    localparam logic [7:0] ADDR_ACT_PERIOD = 8'h18;

    localparam logic [7:0] CH_BASE   = 8'h20;
    localparam int         CH_STRIDE = 8;
    localparam int         CH_SHIFT  = $clog2(CH_STRIDE);

    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE      = 1;
    localparam int CTRL_PRELOAD   = 2;
    localparam int CTRL_FORCE_UPD = 3;
    localparam int CTRL_PENDING   = 4;

    localparam int STAT_UIF       = 0;
    localparam int STAT_CCIF_BASE = 1;

    typedef struct packed {
        logic       period;
        logic       ctrl;
        logic       prescaler;
        logic       deadtime;
        logic       status;
        logic       irq_en;
        logic       act_period;
        logic       ch_hit;
        logic       ch_ccr;    // 0: CCR_ON, 1: CCR
        logic [4:0] ch_idx;
    } dec_t;

    // Channel slots sit at CH_BASE + CH_STRIDE*n; anything past the last channel decodes to nothing.
    function automatic dec_t decode(input logic [7:0] a, input int num_ch);
        dec_t       d;
        logic [7:0] ch_off;
        d          = '0;
        ch_off     = a - CH_BASE;
        d.period     = (a == ADDR_PERIOD);
        d.ctrl       = (a == ADDR_CTRL);
        d.prescaler  = (a == ADDR_PRESCALER);
        d.deadtime   = (a == ADDR_DEADTIME);
        d.status     = (a == ADDR_STATUS);
        d.irq_en     = (a == ADDR_IRQ_EN);
        d.act_period = (a == ADDR_ACT_PERIOD);
        d.ch_idx     = 5'(ch_off >> CH_SHIFT);
        d.ch_ccr     = a[2];
        d.ch_hit     = (a >= CH_BASE) && (a[1:0] == 2'b00) && (int'(d.ch_idx) < num_ch);
        return d;
    endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow/active register pair: bus writes hit the shadow, the active copy drives the PWM core.
module pwm_shadow_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         load,
    input  logic         preload,
    output logic [W-1:0] shadow,
    output logic [W-1:0] active
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr)
                shadow <= wr_data;
            // NOTE: non-blocking, so a load reads the pre-write shadow when a write lands on the same edge.
            if (load)
                active <= shadow;
            if (wr && !preload)
                active <= wr_data;
        end
    end

endmodule

// File: rtl/pwm_regfile_mc.sv
// PWM register file: decode, CTRL/STATUS/IRQ_EN, preload transfer control and registered read port.
module pwm_regfile_mc
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_CH   = 4,
    parameter int PS_WIDTH = 16,
    parameter int DT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [15:0]             addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    input  logic                    update_evt,
    input  logic [NUM_CH-1:0]       cmp_match,
    output logic                    en,
    output logic                    mode,
    output logic [WIDTH-1:0]        period,
    output logic [NUM_CH*WIDTH-1:0] ccr_on,
    output logic [NUM_CH*WIDTH-1:0] ccr,
    output logic [PS_WIDTH-1:0]     prescaler_div,
    output logic [DT_WIDTH-1:0]     deadtime_val,
    output logic                    irq
);

    localparam int SW = NUM_CH + 1;

    dec_t dec;
    logic addr_hi_unused;
    assign dec            = decode(addr[7:0], NUM_CH);
    assign addr_hi_unused = ^addr[15:8];

    logic              preload_q, pending_q;
    logic [SW-1:0]     status_q, irq_en_q;
    logic              wr_period, wr_ps, wr_dt, ctrl_wr, force_upd, xfer, shadow_wr;
    logic [NUM_CH-1:0] wr_ccr_on, wr_ccr;

    assign wr_period = wr_en & dec.period;
    assign wr_ps     = wr_en & dec.prescaler;
    assign wr_dt     = wr_en & dec.deadtime;
    assign ctrl_wr   = wr_en & dec.ctrl;
    assign force_upd = ctrl_wr & wr_data[CTRL_FORCE_UPD];

    always_comb begin
        wr_ccr_on = '0;
        wr_ccr    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && dec.ch_hit && dec.ch_idx == 5'(i)) begin
                wr_ccr_on[i] = ~dec.ch_ccr;
                wr_ccr[i]    = dec.ch_ccr;
            end
        end
    end

    assign shadow_wr = wr_period | wr_ps | wr_dt | (|wr_ccr_on) | (|wr_ccr);
    // A pending transfer left over from preload mode is flushed as soon as PRELOAD reads back 0.
    assign xfer = force_upd | (preload_q & update_evt) | (~preload_q & pending_q);

    logic [WIDTH-1:0]    period_sh;
    logic [PS_WIDTH-1:0] ps_sh;
    logic [DT_WIDTH-1:0] dt_sh;
    logic [WIDTH-1:0]    ccr_on_sh [NUM_CH];
    logic [WIDTH-1:0]    ccr_sh    [NUM_CH];

    pwm_shadow_reg #(.W(WIDTH)) u_period (
        .clk(clk), .rst_n(rst_n), .wr(wr_period), .wr_data(wr_data),
        .load(xfer), .preload(preload_q), .shadow(period_sh), .active(period)
    );

    pwm_shadow_reg #(.W(PS_WIDTH)) u_prescaler (
        .clk(clk), .rst_n(rst_n), .wr(wr_ps), .wr_data(wr_data[PS_WIDTH-1:0]),
        .load(xfer), .preload(preload_q), .shadow(ps_sh), .active(prescaler_div)
    );

    pwm_shadow_reg #(.W(DT_WIDTH)) u_deadtime (
        .clk(clk), .rst_n(rst_n), .wr(wr_dt), .wr_data(wr_data[DT_WIDTH-1:0]),
        .load(xfer), .preload(preload_q), .shadow(dt_sh), .active(deadtime_val)
    );

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        pwm_shadow_reg #(.W(WIDTH)) u_ccr_on (
            .clk(clk), .rst_n(rst_n), .wr(wr_ccr_on[n]), .wr_data(wr_data),
            .load(xfer), .preload(preload_q),
            .shadow(ccr_on_sh[n]), .active(ccr_on[n*WIDTH +: WIDTH])
        );
        pwm_shadow_reg #(.W(WIDTH)) u_ccr (
            .clk(clk), .rst_n(rst_n), .wr(wr_ccr[n]), .wr_data(wr_data),
            .load(xfer), .preload(preload_q),
            .shadow(ccr_sh[n]), .active(ccr[n*WIDTH +: WIDTH])
        );
    end

    logic [SW-1:0] status_set, status_clr;
    assign status_set = {cmp_match, xfer};
    assign status_clr = (wr_en && dec.status) ? wr_data[SW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            mode      <= 1'b0;
            preload_q <= 1'b0;
            pending_q <= 1'b0;
            status_q  <= '0;
            irq_en_q  <= '0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en        <= wr_data[CTRL_EN];
                mode      <= wr_data[CTRL_MODE];
                preload_q <= wr_data[CTRL_PRELOAD];
            end
            // A write racing the transfer keeps PENDING set: its data is still only in the shadow.
            pending_q <= (pending_q & ~xfer) | (shadow_wr & preload_q);
            // Set terms are OR-ed after the clear mask so a coincident event always survives W1C.
            status_q  <= (status_q & ~status_clr) | status_set;
            if (wr_en && dec.irq_en)
                irq_en_q <= wr_data[SW-1:0];
            irq <= |(status_q & irq_en_q);
        end
    end

    logic [WIDTH-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            dec.period:     rd_mux = period_sh;
            dec.ctrl:       rd_mux = WIDTH'({pending_q, 1'b0, preload_q, mode, en});
            dec.prescaler:  rd_mux = WIDTH'(ps_sh);
            dec.deadtime:   rd_mux = WIDTH'(dt_sh);
            dec.status:     rd_mux = WIDTH'(status_q);
            dec.irq_en:     rd_mux = WIDTH'(irq_en_q);
            dec.act_period: rd_mux = period;
            default:        rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (dec.ch_hit && dec.ch_idx == 5'(i))
                rd_mux = dec.ch_ccr ? ccr_sh[i] : ccr_on_sh[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_regfile_mc.sv
// Directed bench for pwm_regfile_mc: preload/immediate transfers, W1C status, irq, decode holes and reset.
module tb_pwm_regfile_mc;

    localparam int WIDTH    = 32;
    localparam int NUM_CH   = 4;
    localparam int PS_WIDTH = 16;
    localparam int DT_WIDTH = 16;

    localparam logic [15:0] A_PERIOD = 16'h00, A_CTRL = 16'h04, A_STATUS = 16'h10;
    localparam logic [15:0] A_IRQ_EN = 16'h14, A_ACT = 16'h18;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    wr_en = 1'b0;
    logic                    rd_en = 1'b0;
    logic [15:0]             addr = '0;
    logic [WIDTH-1:0]        wr_data = '0;
    logic [WIDTH-1:0]        rd_data;
    logic                    rd_valid;
    logic                    update_evt = 1'b0;
    logic [NUM_CH-1:0]       cmp_match = '0;
    logic                    en, mode, irq;
    logic [WIDTH-1:0]        period;
    logic [NUM_CH*WIDTH-1:0] ccr_on, ccr;
    logic [PS_WIDTH-1:0]     prescaler_div;
    logic [DT_WIDTH-1:0]     deadtime_val;

    int vectors = 0;
    int miscompares = 0;

    pwm_regfile_mc #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .PS_WIDTH(PS_WIDTH), .DT_WIDTH(DT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .update_evt(update_evt), .cmp_match(cmp_match), .en(en), .mode(mode),
        .period(period), .ccr_on(ccr_on), .ccr(ccr), .prescaler_div(prescaler_div),
        .deadtime_val(deadtime_val), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_valid"}, 128'(rd_valid), 128'(1));
        check(tag, 128'(rd_data), 128'(exp));
    endtask

    task automatic pulse_upd();
        update_evt = 1'b1;
        @(negedge clk);
        update_evt = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_period", 128'(period), 128'(0));
        check("rst_ccr", ccr, 128'(0));
        check("rst_rd_data", 128'(rd_data), 128'(0));
        check("rst_rd_valid", 128'(rd_valid), 128'(0));
        check("rst_irq", 128'(irq), 128'(0));
        check("rst_en", 128'(en), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: immediate mode
        bus_wr(A_CTRL, 32'h1);
        check("t1_en", 128'(en), 128'(1));
        wr_en = 1'b1; addr = A_PERIOD; wr_data = 32'h1F4;
        #1 check("t1_period_pre", 128'(period), 128'(0));
        @(negedge clk);
        wr_en = 1'b0;
        check("t1_period", 128'(period), 128'(32'h1F4));
        rd_en = 1'b1; addr = A_ACT;
        #1 check("t1_rd_valid_pre", 128'(rd_valid), 128'(0));
        @(negedge clk);
        rd_en = 1'b0;
        check("t1_rd_valid", 128'(rd_valid), 128'(1));
        check("t1_act_period", 128'(rd_data), 128'(32'h1F4));
        @(negedge clk);
        check("t1_rd_valid_drop", 128'(rd_valid), 128'(0));
        check("t1_rd_hold", 128'(rd_data), 128'(32'h1F4));

        // 2: preload, ch2 CCR transfer on update_evt
        bus_wr(A_CTRL, 32'h5);
        bus_wr(16'h34, 32'h80);
        check("t2_ccr2_held", 128'(ccr[2*WIDTH +: WIDTH]), 128'(0));
        bus_rd("t2_ctrl_pending", A_CTRL, 32'h15);
        bus_rd("t2_ccr2_shadow", 16'h34, 32'h80);
        pulse_upd();
        check("t2_ccr2_active", 128'(ccr[2*WIDTH +: WIDTH]), 128'(32'h80));
        bus_rd("t2_ctrl_clear", A_CTRL, 32'h05);
        bus_rd("t2_status_uif", A_STATUS, 32'h1);
        bus_wr(A_STATUS, 32'h1);
        bus_rd("t2_status_w1c", A_STATUS, 32'h0);

        // 3: FORCE_UPD
        bus_wr(A_PERIOD, 32'h64);
        check("t3_period_held", 128'(period), 128'(32'h1F4));
        bus_wr(A_CTRL, 32'h0D);
        check("t3_period_forced", 128'(period), 128'(32'h64));
        bus_rd("t3_ctrl_readback", A_CTRL, 32'h05);
        bus_wr(A_STATUS, 32'h1);

        // 4: CCIF, irq, W1C vs set
        bus_wr(A_IRQ_EN, 32'h4);
        cmp_match = 4'b0010;
        @(negedge clk);
        cmp_match = '0;
        check("t4_irq_lag", 128'(irq), 128'(0));
        @(negedge clk);
        check("t4_irq_set", 128'(irq), 128'(1));
        bus_rd("t4_status", A_STATUS, 32'h4);
        bus_wr(A_STATUS, 32'h4);
        @(negedge clk);
        check("t4_irq_clr", 128'(irq), 128'(0));
        wr_en = 1'b1; addr = A_STATUS; wr_data = 32'h4; cmp_match = 4'b0010;
        @(negedge clk);
        wr_en = 1'b0; cmp_match = '0;
        bus_rd("t4_set_wins", A_STATUS, 32'h4);
        check("t4_irq_again", 128'(irq), 128'(1));
        bus_wr(A_STATUS, 32'h4);
        bus_rd("t4_status_clear", A_STATUS, 32'h0);

        // 5: write coinciding with update_evt
        bus_wr(A_PERIOD, 32'h8);
        pulse_upd();
        check("t5_period_8", 128'(period), 128'(32'h8));
        wr_en = 1'b1; addr = A_PERIOD; wr_data = 32'h10; update_evt = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; update_evt = 1'b0;
        check("t5_period_old_shadow", 128'(period), 128'(32'h8));
        bus_rd("t5_pending", A_CTRL, 32'h15);
        pulse_upd();
        check("t5_period_10", 128'(period), 128'(32'h10));
        bus_rd("t5_pending_clear", A_CTRL, 32'h05);

        // 6: unmapped / out-of-range channel and read-only register
        bus_wr(16'h0040, 32'hDEAD);
        bus_wr(16'h0044, 32'hBEEF);
        bus_wr(16'h001C, 32'h1234);
        bus_wr(A_ACT, 32'h55);
        bus_rd("t6_rd_40", 16'h0040, 32'h0);
        bus_rd("t6_rd_44", 16'h0044, 32'h0);
        bus_rd("t6_rd_1c", 16'h001C, 32'h0);
        bus_rd("t6_act_ro", A_ACT, 32'h10);
        bus_rd("t6_no_pending", A_CTRL, 32'h05);
        check("t6_ccr_all", ccr, 128'(32'h80) << (2*WIDTH));
        check("t6_ccr_on_all", ccr_on, 128'(0));
        check("t6_period", 128'(period), 128'(32'h10));

        // Clearing PRELOAD with a transfer outstanding flushes it on the following edge
        bus_wr(A_STATUS, 32'h1);
        bus_wr(A_PERIOD, 32'h20);
        bus_wr(A_CTRL, 32'h1);
        check("flush_not_yet", 128'(period), 128'(32'h10));
        @(negedge clk);
        check("flush_period", 128'(period), 128'(32'h20));
        bus_rd("flush_uif", A_STATUS, 32'h1);
        bus_rd("flush_ctrl", A_CTRL, 32'h01);

        // Asynchronous reset with a transfer pending
        bus_wr(A_CTRL, 32'h5);
        bus_wr(A_PERIOD, 32'h30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_period", 128'(period), 128'(0));
        check("arst_ccr", ccr, 128'(0));
        check("arst_en", 128'(en), 128'(0));
        check("arst_rd_data", 128'(rd_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulse_upd();
        check("arst_discarded", 128'(period), 128'(0));
        bus_rd("arst_ctrl", A_CTRL, 32'h0);
        bus_rd("arst_shadow", A_PERIOD, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
